tilemap_fetch_sequencer: RTL

//  GFX-side initiator for the shared VRAM arbiter: per 8-pixel group, drives the tilemap VRAM

---
 rtl/tilemap_fetch_sequencer_pkg.sv | 41 ++++
 rtl/tilemap_fetch_sequencer_addr_gen.sv | 83 ++++++++
 rtl/tilemap_fetch_sequencer.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/tilemap_fetch_sequencer_pkg.sv
// Shared definitions for the tilemap fetch sequencer.
// Contents:
//   - default tilemap geometry
//   - slot/phase codes of the emulated timing word ({slot[1:0], phase[2:0]})
//   - fetch FSM state type
//   - attribute bit positions
//   - timing-successor helper
package tilemap_fetch_sequencer_pkg;

    localparam int COLS_LOG2_DEF = 6;
    localparam int ROWS_LOG2_DEF = 5;

    // Timing word codes: {pixel slot, MCLK phase}
    localparam logic [4:0] SLOT_ADDR  = {2'd0, 3'd0};
    localparam logic [4:0] SLOT_CAPT  = {2'd2, 3'd5};
    localparam logic [4:0] SLOT_DONE  = {2'd3, 3'd0};
    localparam logic [2:0] PHASE_LAST = 3'd5;

    // Attribute byte: [7]=vflip [6]=hflip [5:0]=palette
    localparam int ATTR_VFLIP = 7;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_WAIT = 3'd2,
        ST_CAPT = 3'd3,
        ST_DONE = 3'd4
    } fetch_state_e;

    // Timing value that must follow t when the emulated timing runs normally
    function automatic logic [4:0] timing_next(input logic [4:0] t);
        logic [4:0] n;
        if (t[2:0] == PHASE_LAST) begin
            n = {t[4:3] + 2'd1, 3'd0};
        end else begin
            n = {t[4:3], t[2:0] + 3'd1};
        end
        return n;
    endfunction

endpackage

// File: rtl/tilemap_fetch_sequencer_addr_gen.sv
// tm_addr_gen: tilemap VRAM address generator.
// Applies flip and per-layer scroll to the screen counters, packs
// {layer, row, column} and registers it together with the fine Y line
// and the layer bit when load is high; otherwise the last request is held.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   load                       capture a new request this cycle
//   hcounter/vcounter          screen X (bit 2 = layer) / screen Y
//   flip                       bit-invert counters before scroll add
//   scrollx_a/_b, scrolly_a/_b per-layer scroll
//   gfxaddr, finey, layer      registered request
module tm_addr_gen
    import tilemap_fetch_sequencer_pkg::*;
#(
    parameter int COLS_LOG2 = COLS_LOG2_DEF,
    parameter int ROWS_LOG2 = ROWS_LOG2_DEF,
    parameter int ADDR_W    = 1 + ROWS_LOG2 + COLS_LOG2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [8:0]        hcounter,
    input  logic [7:0]        vcounter,
    input  logic              flip,
    input  logic [8:0]        scrollx_a,
    input  logic [8:0]        scrollx_b,
    input  logic [7:0]        scrolly_a,
    input  logic [7:0]        scrolly_b,
    output logic [ADDR_W-1:0] gfxaddr,
    output logic [2:0]        finey,
    output logic              layer
);

    logic                 layer_s;
    logic [8:0]           hc_s;
    logic [8:0]           x_s;
    logic [7:0]           vc_s;
    logic [7:0]           y_s;
    logic [COLS_LOG2-1:0] col_s;
    logic [ROWS_LOG2-1:0] row_s;
    logic [ADDR_W-1:0]    gfxaddr_d, gfxaddr_q;
    logic [2:0]           finey_d, finey_q;
    logic                 layer_d, layer_q;

    // Scrolled tile coordinates (modular wrap) and next request register values
    always_comb begin
        layer_s = hcounter[2];
        hc_s    = flip ? ~hcounter : hcounter;
        vc_s    = flip ? ~vcounter : vcounter;
        x_s     = hc_s + (layer_s ? scrollx_b : scrollx_a);
        y_s     = vc_s + (layer_s ? scrolly_b : scrolly_a);
        // fine X is not needed for the tilemap word, only the column
        col_s   = COLS_LOG2'(x_s >> 3);
        row_s   = y_s[3 +: ROWS_LOG2];
        if (load) begin
            gfxaddr_d = {layer_s, row_s, col_s};
            finey_d   = y_s[2:0];
            layer_d   = layer_s;
        end else begin
            gfxaddr_d = gfxaddr_q;
            finey_d   = finey_q;
            layer_d   = layer_q;
        end
    end

    // Request register: held between loads so the arbiter sees a stable address
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gfxaddr_q <= '0;
            finey_q   <= 3'd0;
            layer_q   <= 1'b0;
        end else begin
            gfxaddr_q <= gfxaddr_d;
            finey_q   <= finey_d;
            layer_q   <= layer_d;
        end
    end

    assign gfxaddr = gfxaddr_q;
    assign finey   = finey_q;
    assign layer   = layer_q;

endmodule

// File: rtl/tilemap_fetch_sequencer.sv
// tilemap_fetch_sequencer: GFX-side tilemap fetcher on the shared VRAM arbiter.
// For every 4-pixel half it issues the tilemap address at timing {0,0},
// captures code/attribute at {2,5} and publishes them for the layer
// (A: HCOUNTER[2]=0, B: HCOUNTER[2]=1) with a one-MCLK strobe visible at {3,1}.
// Any break in the timing sequence abandons the half without a strobe.
// Ports:
//   i_EMU_MCLK, i_EMU_MRST_n       clock, async active-low reset
//   i_EMU_TIMING                   {slot[1:0], phase[2:0]}
//   i_HCOUNTER/i_VCOUNTER/i_FLIP   screen position, flip screen
//   i_SCROLLX_A/_B, i_SCROLLY_A/_B per-layer scroll
//   o_GFXADDR                      tilemap VRAM address to the arbiter
//   i_VRAM1GFXDATA/i_VRAM2GFXDATA  returned tile code / attribute
//   o_TMA_*                        layer A outputs, o_TMA_*_B layer B outputs
module tilemap_fetch_sequencer
    import tilemap_fetch_sequencer_pkg::*;
#(
    parameter int COLS_LOG2 = COLS_LOG2_DEF,
    parameter int ROWS_LOG2 = ROWS_LOG2_DEF,
    parameter int ADDR_W    = 1 + ROWS_LOG2 + COLS_LOG2
) (
    input  logic              i_EMU_MCLK,
    input  logic              i_EMU_MRST_n,
    input  logic [4:0]        i_EMU_TIMING,
    input  logic [8:0]        i_HCOUNTER,
    input  logic [7:0]        i_VCOUNTER,
    input  logic              i_FLIP,
    input  logic [8:0]        i_SCROLLX_A,
    input  logic [8:0]        i_SCROLLX_B,
    input  logic [7:0]        i_SCROLLY_A,
    input  logic [7:0]        i_SCROLLY_B,
    output logic [ADDR_W-1:0] o_GFXADDR,
    input  logic [15:0]       i_VRAM1GFXDATA,
    input  logic [7:0]        i_VRAM2GFXDATA,
    output logic [15:0]       o_TMA_CODE,
    output logic [15:0]       o_TMA_CODE_B,
    output logic [7:0]        o_TMA_ATTR,
    output logic [7:0]        o_TMA_ATTR_B,
    output logic [13:0]       o_TMA_CHARADDR,
    output logic [13:0]       o_TMA_CHARADDR_B,
    output logic              o_TMA_STB,
    output logic              o_TMA_STB_B
);

    logic         rst_meta_d, rst_meta_q;
    logic         rst_sync_d, rst_sync_q;
    fetch_state_e state_d, state_q;
    logic [4:0]   timing_d, timing_q;
    logic [15:0]  pend_code_d, pend_code_q;
    logic [7:0]   pend_attr_d, pend_attr_q;
    logic [15:0]  code_a_d, code_a_q, code_b_d, code_b_q;
    logic [7:0]   attr_a_d, attr_a_q, attr_b_d, attr_b_q;
    logic [13:0]  char_a_d, char_a_q, char_b_d, char_b_q;
    logic         stb_a_d, stb_a_q, stb_b_d, stb_b_q;
    logic         load_s;
    logic         in_seq_s;
    logic [2:0]   finey_s;
    logic         layer_s;
    logic [13:0]  char_s;

    // Synchroniser inputs: release propagates through two flops
    always_comb begin
        rst_meta_d = 1'b1;
        rst_sync_d = rst_meta_q;
    end

    // Reset synchroniser: asserts immediately, releases on the clock
    always_ff @(posedge i_EMU_MCLK or negedge i_EMU_MRST_n) begin
        if (!i_EMU_MRST_n) begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= 1'b0;
        end else begin
            rst_meta_q <= rst_meta_d;
            rst_sync_q <= rst_sync_d;
        end
    end

    tm_addr_gen #(
        .COLS_LOG2 (COLS_LOG2),
        .ROWS_LOG2 (ROWS_LOG2),
        .ADDR_W    (ADDR_W)
    ) u_addr_gen (
        .clk       (i_EMU_MCLK),
        .rst_n     (rst_sync_q),
        .load      (load_s),
        .hcounter  (i_HCOUNTER),
        .vcounter  (i_VCOUNTER),
        .flip      (i_FLIP),
        .scrollx_a (i_SCROLLX_A),
        .scrollx_b (i_SCROLLX_B),
        .scrolly_a (i_SCROLLY_A),
        .scrolly_b (i_SCROLLY_B),
        .gfxaddr   (o_GFXADDR),
        .finey     (finey_s),
        .layer     (layer_s)
    );

    // Fetch FSM next state, capture and publish logic
    always_comb begin
        state_d     = state_q;
        timing_d    = i_EMU_TIMING;
        pend_code_d = pend_code_q;
        pend_attr_d = pend_attr_q;
        code_a_d    = code_a_q;
        attr_a_d    = attr_a_q;
        char_a_d    = char_a_q;
        code_b_d    = code_b_q;
        attr_b_d    = attr_b_q;
        char_b_d    = char_b_q;
        stb_a_d     = 1'b0;
        stb_b_d     = 1'b0;
        load_s      = 1'b0;
        in_seq_s    = (i_EMU_TIMING == timing_next(timing_q));
        // vflip mirrors the 8-line character vertically
        char_s      = {pend_code_q[10:0], finey_s ^ {3{pend_attr_q[ATTR_VFLIP]}}};

        if (i_EMU_TIMING == SLOT_ADDR) begin
            // every {0,0} starts a fresh half, abandoning anything in flight
            load_s  = 1'b1;
            state_d = ST_ADDR;
        end else if ((state_q != ST_IDLE) && !in_seq_s) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_IDLE;
                ST_ADDR: state_d = ST_WAIT;
                ST_WAIT: begin
                    if (i_EMU_TIMING == SLOT_CAPT) begin
                        pend_code_d = i_VRAM1GFXDATA;
                        pend_attr_d = i_VRAM2GFXDATA;
                        state_d     = ST_CAPT;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
                ST_CAPT: begin
                    if (i_EMU_TIMING == SLOT_DONE) begin
                        if (layer_s) begin
                            code_b_d = pend_code_q;
                            attr_b_d = pend_attr_q;
                            char_b_d = char_s;
                            stb_b_d  = 1'b1;
                        end else begin
                            code_a_d = pend_code_q;
                            attr_a_d = pend_attr_q;
                            char_a_d = char_s;
                            stb_a_d  = 1'b1;
                        end
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // FSM state, timing history, pending capture and layer output registers
    always_ff @(posedge i_EMU_MCLK or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            state_q     <= ST_IDLE;
            timing_q    <= 5'd0;
            pend_code_q <= 16'd0;
            pend_attr_q <= 8'd0;
            code_a_q    <= 16'd0;
            attr_a_q    <= 8'd0;
            char_a_q    <= 14'd0;
            code_b_q    <= 16'd0;
            attr_b_q    <= 8'd0;
            char_b_q    <= 14'd0;
            stb_a_q     <= 1'b0;
            stb_b_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            timing_q    <= timing_d;
            pend_code_q <= pend_code_d;
            pend_attr_q <= pend_attr_d;
            code_a_q    <= code_a_d;
            attr_a_q    <= attr_a_d;
            char_a_q    <= char_a_d;
            code_b_q    <= code_b_d;
            attr_b_q    <= attr_b_d;
            char_b_q    <= char_b_d;
            stb_a_q     <= stb_a_d;
            stb_b_q     <= stb_b_d;
        end
    end

    assign o_TMA_CODE       = code_a_q;
    assign o_TMA_ATTR       = attr_a_q;
    assign o_TMA_CHARADDR   = char_a_q;
    assign o_TMA_STB        = stb_a_q;
    assign o_TMA_CODE_B     = code_b_q;
    assign o_TMA_ATTR_B     = attr_b_q;
    assign o_TMA_CHARADDR_B = char_b_q;
    assign o_TMA_STB_B      = stb_b_q;

endmodule
